// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
//   state_e   : controller FSM encoding (IDLE / RUN / DONE)
//   DEF_WIDTH : default operand width
package serial_add_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Full-adder bit-slice used as the serial datapath element.
//   a, b, ci : input bits
//   sum      : {carry_out, sum_bit}
module fa (
  input  logic       a,
  input  logic       b,
  input  logic       ci,
  output logic [1:0] sum
);
  assign sum = {1'b0, a} + {1'b0, b} + {1'b0, ci};
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. Operands are accepted over a valid/ready
// handshake. A single fa slice then walks them LSB-first, one bit per
// clock, with a registered carry. The WIDTH-bit sum and carry-out are
// returned over a second valid/ready handshake.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready  : result handshake (sum, cout)
//   busy                 : high while bits are being stepped (RUN)
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input. When sub is
// high the block computes a - b, and cout = 1 means no borrow.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fa_s;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  fa u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .ci  (carry_q),
    .sum (fa_s)
  );

  // Subtraction is a + ~b + 1: invert b at capture and force the carry in.
`ifdef SERIAL_ADD_SUB_EN
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        // Operands are sampled only on a real transfer, so X on the
        // inputs while idle never reaches state.
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b_cap;
          carry_d  = c_cap;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New sum bits enter at the MSB. After WIDTH shifts the first
        // bit computed has reached bit 0.
        sum_sh_d = {fa_s[0], sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_s[1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  // The result is only exposed while it is valid. Partial sums stay hidden.
  assign sum       = out_valid ? sum_sh_q : '0;
  assign cout      = out_valid ? carry_q : 1'b0;
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, busy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation. hold = number of extra cycles out_ready stays low
  // after out_valid rises. glitch = RUN cycle in which a stray in_valid is
  // pulsed (0 = none).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub,
                        input int hold, input int glitch);
    logic [W:0] exp;
    int n;
    if (tsub) exp = {1'b0, ta} + {1'b0, ~tb_} + (W+1)'(1);
    else      exp = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tcin);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0; a = 'x; b = 'x; cin = 1'bx;
    n = 1;
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    while (!out_valid && n < 4*W) begin
      if (n == glitch) begin in_valid = 1'b1; a = 8'h11; end
      else in_valid = 1'b0;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, W+1);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, exp[W-1:0]);
      chk("hold_cout", cout, exp[W]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    // A stray out_ready while nothing is pending has no effect.
    out_ready = 1'b1;
    repeat (2) tick();
    chk("idle_out_ready", out_valid, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
    run_op(8'hA7, 8'h6E, 1'b1, 1'b0, 5, 0);
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, 3);
    repeat (3) begin
      tick();
      chk("single_pulse", out_valid, 0);
    end

    // Reset in the 4th RUN cycle aborts the operation.
    a = 8'h33; b = 8'h44; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    for (int i = 0; i < W+3; i++) begin
      tick();
      chk("abort_no_result", out_valid, 0);
    end

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 0);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, 0);
`endif

    for (int k = 0; k < 25; k++) begin
      logic ts;
`ifdef SERIAL_ADD_SUB_EN
      ts = 1'($urandom_range(0, 1));
`else
      ts = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ts,
             int'($urandom_range(0, 3)), int'($urandom_range(0, W-1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
